// File: rtl/addsub_pkg.sv
//------------------------------------------------------------------------------
// Module  : addsub_pkg
// Brief   : Shared opcode and state encodings for the bit-serial add/sub unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

`default_nettype wire

// File: rtl/addsub_cell.sv
//------------------------------------------------------------------------------
// Module  : addsub_cell
// Brief   : Combinational 1-bit full-adder / full-subtractor cell.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addsub_cell
    import addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cbin,
    input  logic op,
    output logic s,
    output logic cbout
);

    logic w_xy;

    assign w_xy  = x ^ y;
    assign s     = w_xy ^ cbin;
    assign cbout = (op == OP_SUB) ? ((~x & (y | cbin)) | (y & cbin))
                                  : ((x & y) | (cbin & w_xy));

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
//------------------------------------------------------------------------------
// Module  : serial_addsub
// Brief   : Bit-serial WIDTH-bit adder/subtractor, LSB-first, start/done handshake.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cb_out
);

    localparam int             c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_op;
    logic               r_cb;
    logic [WIDTH-1:0]   r_result;
    logic               r_cb_out;
    logic               w_s;
    logic               w_cbout;
    logic               w_last;

    addsub_cell u_cell (
        .x     (r_a[0]),
        .y     (r_b[0]),
        .cbin  (r_cb),
        .op    (r_op),
        .s     (w_s),
        .cbout (w_cbout)
    );

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result bits are shifted into the vacated top of the a-register, so after
    // WIDTH steps r_a holds the full answer without a separate accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_cb     <= 1'b0;
            r_result <= '0;
            r_cb_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_op  <= op;
                        r_cb  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_a   <= {w_s, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_cb  <= w_cbout;
                    r_cnt <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        r_result <= {w_s, r_a[WIDTH-1:1]};
                        r_cb_out <= w_cbout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign cb_out = r_cb_out;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
//------------------------------------------------------------------------------
// Module  : tb_serial_addsub
// Brief   : Scoreboard bench for serial_addsub with directed and random operations.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_addsub;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             op    = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cb_out;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cb_out (cb_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cb;
        int               due;
        string            tag;
    } exp_t;

    exp_t             q[$];
    logic [WIDTH-1:0] hold_res = '0;
    logic             hold_cb  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic; borrow is simply a < b.
    function automatic logic [WIDTH:0] model(input logic o, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] diff;
        if (o == 1'b0) return (WIDTH+1)'(x) + (WIDTH+1)'(y);
        diff = x - y;
        return {(x < y), diff};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    check({e.tag, "_result"}, 32'(result), 32'(e.res));
                    check({e.tag, "_cb_out"}, 32'(cb_out), 32'(e.cb));
                    check({e.tag, "_latency"}, 32'(cyc), 32'(e.due));
                    hold_res = e.res;
                    hold_cb  = e.cb;
                end
            end else if (rst_n && busy) begin
                check("hold_during_run", 32'({cb_out, result}), 32'({hold_cb, hold_res}));
            end
        end
    end

    task automatic wait_ready(input string tag);
        int waited = 0;
        @(negedge clk);
        while (!ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) check({tag, "_ready_timeout"}, 32'(ready), 32'd1);
    endtask

    task automatic do_op(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input string tag);
        logic [WIDTH:0] m;
        exp_t           e;
        wait_ready(tag);
        if (ready) begin
            op    = o;
            a     = x;
            b     = y;
            start = 1'b1;
            m     = model(o, x, y);
            e.res = m[WIDTH-1:0];
            e.cb  = m[WIDTH];
            e.due = cyc + 1 + WIDTH;
            e.tag = tag;
            q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            op    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},  32'(ready),  32'd1);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_done"},   32'(done),   32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_cb_out"}, 32'(cb_out), 32'd0);
    endtask

    initial begin : driver
        int gap;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        do_op(1'b0, 8'h3C, 8'h15, "add_3c_15");
        do_op(1'b0, 8'hFF, 8'h01, "add_ff_01");
        do_op(1'b1, 8'h00, 8'h01, "sub_00_01");
        do_op(1'b1, 8'h55, 8'h55, "sub_55_55");
        do_op(1'b1, 8'h80, 8'h7F, "sub_80_7f");

        // A start during RUN must be dropped, not queued or re-latched.
        do_op(1'b0, 8'h20, 8'h02, "add_20_02_ign");
        repeat (2) @(negedge clk);
        a     = 8'h11;
        b     = 8'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Abort mid-RUN: no done may follow and the result must clear.
        wait_ready("abort");
        op    = 1'b0;
        a     = 8'h20;
        b     = 8'h02;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        hold_res = '0;
        hold_cb  = 1'b0;
        check_reset_state("abort");

        do_op(1'b0, 8'h01, 8'h01, "add_01_01");
        do_op(1'b1, 8'h10, 8'h20, "b2b_sub_10_20");
        do_op(1'b0, 8'h7F, 8'h01, "b2b_add_7f_01");

        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            do_op(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom), "rand");
        end

        begin
            int waited = 0;
            while (q.size() != 0 && waited < 200) begin
                @(negedge clk);
                waited++;
            end
        end
        check("queue_drain", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
